// File: rtl/imem_loader.sv
// Boot-time loader: unpacks a length/data/checksum byte frame into little-endian 32-bit imem
// writes, and holds the RV32I core in reset until a checksum-valid image has been loaded.
module imem_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_waddr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        err_code_o
);

  // Counter only has to reach TIMEOUT-1; the cycle after that is the expiry.
  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
  localparam logic [16:0] CapWords = 17'(2 ** ADDR_W);

  localparam logic [1:0] ErrNone = 2'b00;
  localparam logic [1:0] ErrLen  = 2'b01;
  localparam logic [1:0] ErrCsum = 2'b10;
  localparam logic [1:0] ErrTmo  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       shift_q, shift_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;

  logic              rx_ready_q, rx_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_out_q, waddr_out_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        err_q, err_d;

  logic              xfer;
  logic [15:0]       len_full;
  logic              loading;

  assign xfer     = rx_valid_i & rx_ready_q;
  assign len_full = {rx_data_i, len_q[7:0]};
  assign loading  = state_q inside {StLen0, StLen1, StData, StCsum};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wcnt_d      = wcnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    csum_d      = csum_q;
    waddr_d     = waddr_q;
    tmo_d       = tmo_q;
    we_d        = 1'b0;
    waddr_out_d = waddr_out_q;
    wdata_d     = wdata_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) begin
          state_d = StLen0;
          csum_d  = 8'd0;
          idx_d   = 2'd0;
          waddr_d = '0;
          wcnt_d  = 16'd0;
          tmo_d   = '0;
          err_d   = ErrNone;
        end
      end
      StLen0: begin
        if (xfer) begin
          len_d[7:0] = rx_data_i;
          state_d    = StLen1;
        end
      end
      StLen1: begin
        if (xfer) begin
          len_d[15:8] = rx_data_i;
          if ({1'b0, len_full} > CapWords) begin
            state_d = StErr;
            err_d   = ErrLen;
          end else if (len_full == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          csum_d = csum_q + rx_data_i;
          idx_d  = idx_q + 2'd1;
          unique case (idx_q)
            2'd0: shift_d[7:0]   = rx_data_i;
            2'd1: shift_d[15:8]  = rx_data_i;
            2'd2: shift_d[23:16] = rx_data_i;
            default: begin
              we_d        = 1'b1;
              waddr_out_d = waddr_q;
              wdata_d     = {rx_data_i, shift_q};
              waddr_d     = waddr_q + ADDR_W'(1);
              wcnt_d      = wcnt_q + 16'd1;
              if (wcnt_q == len_q - 16'd1) begin
                state_d = StCsum;
              end
            end
          endcase
        end
      end
      StCsum: begin
        if (xfer) begin
          if (rx_data_i == csum_q) begin
            state_d = StDone;
          end else begin
            state_d = StErr;
            err_d   = ErrCsum;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A transfer in the expiry cycle wins over the timeout.
    if (loading) begin
      if (xfer) begin
        tmo_d = '0;
      end else if (tmo_q == TmoLast) begin
        state_d = StErr;
        err_d   = ErrTmo;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end

    busy_d     = state_d inside {StLen0, StLen1, StData, StCsum};
    rx_ready_d = busy_d;
    done_d     = (state_d == StDone);
    cpu_hold_d = (state_d != StDone);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      len_q       <= 16'd0;
      wcnt_q      <= 16'd0;
      idx_q       <= 2'd0;
      shift_q     <= 24'd0;
      csum_q      <= 8'd0;
      waddr_q     <= '0;
      tmo_q       <= '0;
      rx_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      waddr_out_q <= '0;
      wdata_q     <= 32'd0;
      cpu_hold_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ErrNone;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wcnt_q      <= wcnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      csum_q      <= csum_d;
      waddr_q     <= waddr_d;
      tmo_q       <= tmo_d;
      rx_ready_q  <= rx_ready_d;
      we_q        <= we_d;
      waddr_out_q <= waddr_out_d;
      wdata_q     <= wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rx_ready_o   = rx_ready_q;
  assign imem_we_o    = we_q;
  assign imem_waddr_o = waddr_out_q;
  assign imem_wdata_o = wdata_q;
  assign cpu_hold_o   = cpu_hold_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_code_o   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised frame bench for imem_loader: a frame-level model predicts imem writes (scoreboard
// queue popped by a write monitor) and the final loader status.
module tb_imem_loader;
  localparam int unsigned AW  = 8;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ready, imem_we, cpu_hold, busy, done;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [1:0]    err_code;

  imem_loader #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready), .imem_we_o(imem_we), .imem_waddr_o(imem_waddr),
    .imem_wdata_o(imem_wdata), .cpu_hold_o(cpu_hold), .busy_o(busy), .done_o(done),
    .err_code_o(err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] data;
    logic [7:0]  addr;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  frame_q[$];
  logic [31:0] cyc = 32'd0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [7:0]  last_addr = 8'd0;
  logic [31:0] last_data = 32'd0;

  int          m_n;
  bit          m_over;
  bit          m_done;
  logic [1:0]  m_err;
  logic [31:0] m_words[$];

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Write monitor: every imem_we pulse must match the oldest predicted write.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && imem_we) begin
      check("we_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("we_addr", 32'(imem_waddr), 32'(e.addr));
        check("we_data", imem_wdata, e.data);
        check("we_cycle", cyc, e.cyc);
      end
    end
  end

  // Frame-level reference: what a correct loader writes and how it ends.
  task automatic model_frame();
    logic [7:0] sum;
    m_n    = int'({frame_q[1], frame_q[0]});
    m_over = (m_n > (1 << AW));
    m_words.delete();
    if (m_over) begin
      m_done = 1'b0;
      m_err  = 2'b01;
    end else begin
      sum = 8'd0;
      for (int j = 0; j < m_n; j++)
        m_words.push_back({frame_q[2+4*j+3], frame_q[2+4*j+2], frame_q[2+4*j+1], frame_q[2+4*j]});
      for (int i = 0; i < 4 * m_n; i++) sum = sum + frame_q[2+i];
      m_done = (frame_q[2+4*m_n] == sum);
      m_err  = m_done ? 2'b00 : 2'b10;
    end
  endtask

  task automatic build_frame(input int n, input bit bad);
    logic [7:0] s;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'(n));
    frame_q.push_back(8'(n >> 8));
    if (n <= (1 << AW)) begin
      s = 8'd0;
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        frame_q.push_back(b);
        s = s + b;
      end
      frame_q.push_back(bad ? s + 8'($urandom_range(1, 255)) : s);
    end
  endtask

  // One clock cycle of input drive; acc reports whether a byte transferred at the coming edge.
  task automatic cyc_drive(input logic v, input logic [7:0] d, input logic s,
                           output logic acc, output logic [31:0] k);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    start    = s;
    acc      = v & rx_ready;
    k        = cyc;
    @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapmax, input bit strict,
                           output logic acc, output logic [31:0] k);
    int gap;
    int tries;
    logic a;
    logic [31:0] kk;
    gap = strict ? 0 : int'($urandom_range(0, gapmax));
    // Idle gaps also carry stray start pulses, which must be ignored while busy.
    repeat (gap) cyc_drive(1'b0, 8'($urandom), 1'($urandom_range(0, 3) == 0), a, kk);
    acc   = 1'b0;
    tries = 0;
    k     = 32'd0;
    while (!acc && tries < 40) begin
      cyc_drive(1'b1, b, 1'b0, acc, k);
      tries++;
    end
    check("byte_accept", 32'(acc), 32'd1);
    if (strict) check("no_stall", 32'(tries), 32'd1);
  endtask

  task automatic run_frame(input int gapmax, input bit strict);
    logic acc;
    logic [31:0] k;
    int j;
    model_frame();
    cyc_drive(1'b0, 8'h00, 1'b1, acc, k);
    #1;
    check("start_busy", 32'(busy), 32'd1);
    check("start_hold", 32'(cpu_hold), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_err", 32'(err_code), 32'd0);
    check("start_ready", 32'(rx_ready), 32'd1);
    foreach (frame_q[i]) begin
      send_byte(frame_q[i], gapmax, strict, acc, k);
      if (!acc) break;
      if (i == 1) begin
        #1;
        check("len_busy", 32'(busy), 32'(!m_over));
        check("len_err", 32'(err_code), m_over ? 32'd1 : 32'd0);
      end
      if (!m_over && i >= 2 && i < 2 + 4 * m_n && (i - 2) % 4 == 3) begin
        j = (i - 2) / 4;
        exp_q.push_back('{cyc: k + 32'd1, data: m_words[j], addr: 8'(j)});
        last_addr = 8'(j);
        last_data = m_words[j];
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
    check("end_done", 32'(done), 32'(m_done));
    check("end_err", 32'(err_code), 32'(m_err));
    check("end_hold", 32'(cpu_hold), 32'(!m_done));
    check("end_busy", 32'(busy), 32'd0);
    check("end_ready", 32'(rx_ready), 32'd0);
    check("end_pending", 32'(exp_q.size()), 32'd0);
    check("end_waddr", 32'(imem_waddr), 32'(last_addr));
    check("end_wdata", imem_wdata, last_data);
    // Bytes offered while not ready must not disturb the terminal state.
    repeat (3) cyc_drive(1'b1, 8'($urandom), 1'b0, acc, k);
    #1;
    check("idle_done", 32'(done), 32'(m_done));
    check("idle_err", 32'(err_code), 32'(m_err));
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t reached, limit 2000000", $time);
    $fatal(1);
  end

  initial begin
    logic acc;
    logic [31:0] k;
    logic [7:0] s;
    int t;

    #12;
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_ready", 32'(rx_ready), 32'd0);
    check("rst_err", 32'(err_code), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_waddr", 32'(imem_waddr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (2) begin
      cyc_drive(1'b1, 8'h55, 1'b0, acc, k);
      check("idle_no_accept", 32'(acc), 32'd0);
    end

    // Two-instruction image, good then corrupted checksum.
    frame_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    s = 8'd0;
    for (int i = 2; i < 10; i++) s = s + frame_q[i];
    frame_q.push_back(s);
    run_frame(3, 1'b0);
    frame_q[10] = s + 8'd1;
    run_frame(3, 1'b0);

    frame_q = '{8'h01, 8'h01};
    run_frame(2, 1'b0);
    frame_q = '{8'h00, 8'h00, 8'h00};
    run_frame(2, 1'b0);

    build_frame(3, 1'b0);
    run_frame(0, 1'b1);
    build_frame(1 << AW, 1'b0);
    run_frame(0, 1'b1);

    repeat (12) begin
      if ($urandom_range(0, 7) == 0) build_frame(257 + int'($urandom_range(0, 500)), 1'b0);
      else build_frame(int'($urandom_range(0, 6)), $urandom_range(0, 3) == 0);
      run_frame(3, 1'b0);
    end

    // Stall after two data bytes.
    build_frame(2, 1'b0);
    cyc_drive(1'b0, 8'h00, 1'b1, acc, k);
    for (int i = 0; i < 4; i++) send_byte(frame_q[i], 0, 1'b1, acc, k);
    t = 0;
    while (t < 40) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (err_code == 2'b11) break;
      t++;
    end
    check("tmo_err", 32'(err_code), 32'd3);
    check("tmo_cycle", cyc, k + 32'd17);
    check("tmo_hold", 32'(cpu_hold), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a data word.
    build_frame(2, 1'b0);
    cyc_drive(1'b0, 8'h00, 1'b1, acc, k);
    for (int i = 0; i < 5; i++) send_byte(frame_q[i], 0, 1'b1, acc, k);
    @(negedge clk);
    rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(rx_ready), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_hold", 32'(cpu_hold), 32'd1);
    check("arst_err", 32'(err_code), 32'd0);
    check("arst_we", 32'(imem_we), 32'd0);
    last_addr = 8'd0;
    last_data = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;

    build_frame(4, 1'b0);
    run_frame(2, 1'b0);

    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
